// File: rtl/core_wb_if.sv
// rtl/core_wb_if.sv - memory-access to write-back record, register-file and CSR write ports
interface core_wb_if;
  logic        mw_valid;
  logic        mw_ready;
  logic [31:0] mw_reg_data;
  logic [31:0] mw_mem_data;
  logic        mw_mem_data_valid;
  logic [31:0] mw_csr_data;
  logic [4:0]  mw_rd;
  logic        mw_reg_write;
  logic        mw_reg_write_sel;
  logic [11:0] mw_csr;
  logic        mw_csr_write;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        wb_retire;
  logic [63:0] wb_instret;
  logic        wb_load_timeout;

  modport slave (
    input  mw_valid, mw_reg_data, mw_mem_data, mw_mem_data_valid, mw_csr_data,
           mw_rd, mw_reg_write, mw_reg_write_sel, mw_csr, mw_csr_write,
    output mw_ready, rf_we, rf_waddr, rf_wdata, csr_we, csr_waddr, csr_wdata,
           wb_retire, wb_instret, wb_load_timeout
  );

  modport master (
    output mw_valid, mw_reg_data, mw_mem_data, mw_mem_data_valid, mw_csr_data,
           mw_rd, mw_reg_write, mw_reg_write_sel, mw_csr, mw_csr_write,
    input  mw_ready, rf_we, rf_waddr, rf_wdata, csr_we, csr_waddr, csr_wdata,
           wb_retire, wb_instret, wb_load_timeout
  );
endinterface

// File: rtl/core_wb.sv
// rtl/core_wb.sv - write-back stage: commits retired records to the register file and CSR file
module core_wb #(
  parameter int unsigned LOAD_TIMEOUT = 64
) (
  input  logic      clk,
  input  logic      rest,
  core_wb_if.slave  bus
);

  localparam logic [15:0] WaitLast = 16'(LOAD_TIMEOUT - 1);

  typedef enum logic {IDLE, LOAD_WAIT} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic        ld_csr_we_q, ld_csr_we_d;
  logic [11:0] ld_csr_q, ld_csr_d;
  logic [31:0] ld_csr_data_q, ld_csr_data_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic        csr_we_q, csr_we_d;
  logic [11:0] csr_waddr_q, csr_waddr_d;
  logic [31:0] csr_wdata_q, csr_wdata_d;
  logic        retire_q, retire_d;
  logic [63:0] instret_q, instret_d;
  logic        timeout_q, timeout_d;

  logic accept;
  logic is_load;

  assign accept  = bus.mw_valid && (state_q == IDLE);
  assign is_load = bus.mw_reg_write && bus.mw_reg_write_sel;

  always_ff @(posedge clk) begin
    if (rest) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ld_rd_q       <= '0;
      ld_csr_we_q   <= 1'b0;
      ld_csr_q      <= '0;
      ld_csr_data_q <= '0;
      rf_we_q       <= 1'b0;
      rf_waddr_q    <= '0;
      rf_wdata_q    <= '0;
      csr_we_q      <= 1'b0;
      csr_waddr_q   <= '0;
      csr_wdata_q   <= '0;
      retire_q      <= 1'b0;
      instret_q     <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ld_rd_q       <= ld_rd_d;
      ld_csr_we_q   <= ld_csr_we_d;
      ld_csr_q      <= ld_csr_d;
      ld_csr_data_q <= ld_csr_data_d;
      rf_we_q       <= rf_we_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_wdata_q    <= rf_wdata_d;
      csr_we_q      <= csr_we_d;
      csr_waddr_q   <= csr_waddr_d;
      csr_wdata_q   <= csr_wdata_d;
      retire_q      <= retire_d;
      instret_q     <= instret_d;
      timeout_q     <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept && is_load && !bus.mw_mem_data_valid) state_d = LOAD_WAIT;
      LOAD_WAIT: if (bus.mw_mem_data_valid || cnt_q == WaitLast) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Address/data registers only move when their enable fires, so they hold between writes.
  always_comb begin
    cnt_d         = cnt_q;
    ld_rd_d       = ld_rd_q;
    ld_csr_we_d   = ld_csr_we_q;
    ld_csr_d      = ld_csr_q;
    ld_csr_data_d = ld_csr_data_q;
    rf_we_d       = 1'b0;
    rf_waddr_d    = rf_waddr_q;
    rf_wdata_d    = rf_wdata_q;
    csr_we_d      = 1'b0;
    csr_waddr_d   = csr_waddr_q;
    csr_wdata_d   = csr_wdata_q;
    retire_d      = 1'b0;
    timeout_d     = timeout_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_load && !bus.mw_mem_data_valid) begin
            cnt_d         = '0;
            ld_rd_d       = bus.mw_rd;
            ld_csr_we_d   = bus.mw_csr_write;
            ld_csr_d      = bus.mw_csr;
            ld_csr_data_d = bus.mw_csr_data;
          end else begin
            retire_d = 1'b1;
            if (bus.mw_reg_write && bus.mw_rd != 5'd0) begin
              rf_we_d    = 1'b1;
              rf_waddr_d = bus.mw_rd;
              rf_wdata_d = is_load ? bus.mw_mem_data : bus.mw_reg_data;
            end
            if (bus.mw_csr_write) begin
              csr_we_d    = 1'b1;
              csr_waddr_d = bus.mw_csr;
              csr_wdata_d = bus.mw_csr_data;
            end
          end
        end
      end
      LOAD_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (bus.mw_mem_data_valid) begin
          retire_d = 1'b1;
          if (ld_rd_q != 5'd0) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = ld_rd_q;
            rf_wdata_d = bus.mw_mem_data;
          end
          if (ld_csr_we_q) begin
            csr_we_d    = 1'b1;
            csr_waddr_d = ld_csr_q;
            csr_wdata_d = ld_csr_data_q;
          end
        end else if (cnt_q == WaitLast) begin
          retire_d  = 1'b1;
          timeout_d = 1'b1;
        end
      end
      default: ;
    endcase
    instret_d = instret_q + {63'd0, retire_d};
  end

  assign bus.mw_ready        = (state_q == IDLE);
  assign bus.rf_we           = rf_we_q;
  assign bus.rf_waddr        = rf_waddr_q;
  assign bus.rf_wdata        = rf_wdata_q;
  assign bus.csr_we          = csr_we_q;
  assign bus.csr_waddr       = csr_waddr_q;
  assign bus.csr_wdata       = csr_wdata_q;
  assign bus.wb_retire       = retire_q;
  assign bus.wb_instret      = instret_q;
  assign bus.wb_load_timeout = timeout_q;

endmodule

// File: tb/tb_core_wb.sv
// tb/tb_core_wb.sv - self-checking bench for core_wb: vector table, corner sequences, randomized model
module tb_core_wb;
  localparam int TMO = 4;

  typedef struct {
    logic        valid;
    logic [4:0]  rd;
    logic        rw;
    logic        sel;
    logic [31:0] rdata;
    logic [31:0] mdata;
    logic        mdv;
    logic        cw;
    logic [11:0] csr;
    logic [31:0] cdata;
  } rec_t;

  typedef struct {
    rec_t        in;
    logic        e_rf_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_csr_we;
    logic [11:0] e_caddr;
    logic [31:0] e_cdata;
    logic        e_retire;
  } vec_t;

  logic clk = 1'b0;
  logic rest = 1'b1;
  always #5 clk = ~clk;

  core_wb_if bus ();
  core_wb #(.LOAD_TIMEOUT(TMO)) dut (.clk(clk), .rest(rest), .bus(bus));

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];

  rec_t        pend[$];
  int          waited;
  logic        m_rf_we, m_csr_we, m_retire, m_tmo;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata, m_cdata;
  logic [11:0] m_caddr;
  logic [63:0] m_instret;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic rec_t mk(logic v, logic [4:0] rd, logic rw, logic sel, logic [31:0] rdata,
                              logic [31:0] mdata, logic mdv, logic cw, logic [11:0] csr, logic [31:0] cdata);
    rec_t r;
    r.valid = v; r.rd = rd; r.rw = rw; r.sel = sel; r.rdata = rdata;
    r.mdata = mdata; r.mdv = mdv; r.cw = cw; r.csr = csr; r.cdata = cdata;
    return r;
  endfunction

  task automatic apply(input rec_t r);
    bus.mw_valid          = r.valid;
    bus.mw_rd             = r.rd;
    bus.mw_reg_write      = r.rw;
    bus.mw_reg_write_sel  = r.sel;
    bus.mw_reg_data       = r.rdata;
    bus.mw_mem_data       = r.mdata;
    bus.mw_mem_data_valid = r.mdv;
    bus.mw_csr_write      = r.cw;
    bus.mw_csr            = r.csr;
    bus.mw_csr_data       = r.cdata;
  endtask

  task automatic add_vec(input rec_t r, input logic rwe, input logic [4:0] wa, input logic [31:0] wd,
                         input logic cwe, input logic [11:0] ca, input logic [31:0] cd, input logic ret);
    vec_t v;
    v.in = r; v.e_rf_we = rwe; v.e_waddr = wa; v.e_wdata = wd;
    v.e_csr_we = cwe; v.e_caddr = ca; v.e_cdata = cd; v.e_retire = ret;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rest = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    rest = 1'b0;
  endtask

  task automatic check_zero(input string p);
    chk({p, "_ready"}, 64'(bus.mw_ready), 64'd1);
    chk({p, "_rf_we"}, 64'(bus.rf_we), 64'd0);
    chk({p, "_rf_waddr"}, 64'(bus.rf_waddr), 64'd0);
    chk({p, "_rf_wdata"}, 64'(bus.rf_wdata), 64'd0);
    chk({p, "_csr_we"}, 64'(bus.csr_we), 64'd0);
    chk({p, "_csr_waddr"}, 64'(bus.csr_waddr), 64'd0);
    chk({p, "_csr_wdata"}, 64'(bus.csr_wdata), 64'd0);
    chk({p, "_retire"}, 64'(bus.wb_retire), 64'd0);
    chk({p, "_instret"}, bus.wb_instret, 64'd0);
    chk({p, "_timeout"}, 64'(bus.wb_load_timeout), 64'd0);
  endtask

  // Reference: a record is either committed at once or parked until data arrives or patience runs out.
  task automatic model_commit(input rec_t r, input logic [31:0] load_data);
    m_retire = 1'b1;
    m_instret++;
    if (r.rw && r.rd != 0) begin
      m_rf_we = 1'b1; m_waddr = r.rd; m_wdata = r.sel ? load_data : r.rdata;
    end
    if (r.cw) begin
      m_csr_we = 1'b1; m_caddr = r.csr; m_cdata = r.cdata;
    end
  endtask

  task automatic model_edge(input rec_t r, input logic rst);
    m_rf_we = 1'b0; m_csr_we = 1'b0; m_retire = 1'b0;
    if (rst) begin
      pend.delete();
      m_waddr = '0; m_wdata = '0; m_caddr = '0; m_cdata = '0; m_instret = '0; m_tmo = 1'b0;
    end else if (pend.size() == 0) begin
      if (r.valid) begin
        if (r.rw && r.sel && !r.mdv) begin
          pend.push_back(r);
          waited = 0;
        end else begin
          model_commit(r, r.mdata);
        end
      end
    end else begin
      waited++;
      if (r.mdv) begin
        model_commit(pend[0], r.mdata);
        pend.delete();
      end else if (waited == TMO) begin
        pend.delete();
        m_tmo = 1'b1; m_retire = 1'b1; m_instret++;
      end
    end
  endtask

  initial begin
    rec_t idle;
    rec_t r;
    logic rst;
    logic [63:0] exp_ir;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    add_vec(mk(1, 1, 1, 0, 32'h11, 0, 0, 0, 0, 0), 1, 1, 32'h11, 0, 0, 0, 1);
    add_vec(mk(1, 2, 1, 0, 32'h22, 0, 0, 0, 0, 0), 1, 2, 32'h22, 0, 0, 0, 1);
    add_vec(mk(1, 3, 1, 0, 32'h33, 0, 0, 0, 0, 0), 1, 3, 32'h33, 0, 0, 0, 1);
    add_vec(mk(1, 5, 1, 1, 32'h1234, 32'hDEADBEEF, 1, 0, 0, 0), 1, 5, 32'hDEADBEEF, 0, 0, 0, 1);
    add_vec(mk(1, 0, 1, 0, 32'h99, 0, 0, 1, 12'h300, 32'h8), 0, 0, 0, 1, 12'h300, 32'h8, 1);
    add_vec(idle, 0, 0, 0, 0, 0, 0, 0);
    add_vec(mk(0, 4, 1, 1, 0, 32'hFFFF, 1, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0);
    add_vec(mk(1, 4, 0, 1, 32'h44, 0, 0, 1, 12'h341, 32'hABCD), 0, 0, 0, 1, 12'h341, 32'hABCD, 1);
    add_vec(mk(1, 31, 1, 1, 0, 32'h7F, 1, 1, 12'h305, 32'h100), 1, 31, 32'h7F, 1, 12'h305, 32'h100, 1);
    add_vec(mk(1, 6, 1, 0, 32'hCAFE, 32'h1, 1, 0, 0, 0), 1, 6, 32'hCAFE, 0, 0, 0, 1);

    do_reset();
    check_zero("reset");

    exp_ir = 0;
    foreach (vecs[i]) begin
      apply(vecs[i].in);
      tick();
      if (vecs[i].e_retire) exp_ir++;
      chk($sformatf("vec%0d_rf_we", i), 64'(bus.rf_we), 64'(vecs[i].e_rf_we));
      if (vecs[i].e_rf_we) begin
        chk($sformatf("vec%0d_rf_waddr", i), 64'(bus.rf_waddr), 64'(vecs[i].e_waddr));
        chk($sformatf("vec%0d_rf_wdata", i), 64'(bus.rf_wdata), 64'(vecs[i].e_wdata));
      end
      chk($sformatf("vec%0d_csr_we", i), 64'(bus.csr_we), 64'(vecs[i].e_csr_we));
      if (vecs[i].e_csr_we) begin
        chk($sformatf("vec%0d_csr_waddr", i), 64'(bus.csr_waddr), 64'(vecs[i].e_caddr));
        chk($sformatf("vec%0d_csr_wdata", i), 64'(bus.csr_wdata), 64'(vecs[i].e_cdata));
      end
      chk($sformatf("vec%0d_retire", i), 64'(bus.wb_retire), 64'(vecs[i].e_retire));
      chk($sformatf("vec%0d_ready", i), 64'(bus.mw_ready), 64'd1);
      chk($sformatf("vec%0d_instret", i), bus.wb_instret, exp_ir);
    end

    // Delayed load: data arrives on the fourth wait cycle, coinciding with expiry.
    do_reset();
    apply(mk(1, 7, 1, 1, 0, 0, 0, 0, 0, 0));
    tick();
    chk("dly_ready_0", 64'(bus.mw_ready), 64'd0);
    chk("dly_retire_0", 64'(bus.wb_retire), 64'd0);
    apply(idle);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("dly_ready_%0d", k), 64'(bus.mw_ready), 64'd0);
      chk($sformatf("dly_rf_we_%0d", k), 64'(bus.rf_we), 64'd0);
    end
    apply(mk(1, 8, 1, 0, 32'h55, 32'h80000000, 1, 0, 0, 0));
    tick();
    chk("dly_rf_we", 64'(bus.rf_we), 64'd1);
    chk("dly_rf_waddr", 64'(bus.rf_waddr), 64'd7);
    chk("dly_rf_wdata", 64'(bus.rf_wdata), 64'h80000000);
    chk("dly_retire", 64'(bus.wb_retire), 64'd1);
    chk("dly_ready", 64'(bus.mw_ready), 64'd1);
    chk("dly_no_timeout", 64'(bus.wb_load_timeout), 64'd0);
    chk("dly_instret", bus.wb_instret, 64'd1);
    apply(mk(1, 8, 1, 0, 32'h55, 0, 0, 0, 0, 0));
    tick();
    chk("dly_next_waddr", 64'(bus.rf_waddr), 64'd8);
    chk("dly_next_wdata", 64'(bus.rf_wdata), 64'h55);
    chk("dly_next_instret", bus.wb_instret, 64'd2);

    // Timeout with a latched CSR write that must be suppressed.
    do_reset();
    apply(mk(1, 9, 1, 1, 0, 0, 0, 1, 12'h340, 32'h77));
    tick();
    chk("tmo_ready_0", 64'(bus.mw_ready), 64'd0);
    apply(idle);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("tmo_ready_%0d", k), 64'(bus.mw_ready), 64'd0);
      chk($sformatf("tmo_flag_%0d", k), 64'(bus.wb_load_timeout), 64'd0);
    end
    tick();
    chk("tmo_ready", 64'(bus.mw_ready), 64'd1);
    chk("tmo_retire", 64'(bus.wb_retire), 64'd1);
    chk("tmo_rf_we", 64'(bus.rf_we), 64'd0);
    chk("tmo_csr_we", 64'(bus.csr_we), 64'd0);
    chk("tmo_flag", 64'(bus.wb_load_timeout), 64'd1);
    chk("tmo_instret", bus.wb_instret, 64'd1);
    apply(mk(1, 1, 1, 0, 32'h5, 0, 0, 0, 0, 0));
    tick();
    chk("tmo_sticky", 64'(bus.wb_load_timeout), 64'd1);
    chk("tmo_after_rf_we", 64'(bus.rf_we), 64'd1);
    chk("tmo_after_instret", bus.wb_instret, 64'd2);

    // Reset while waiting on a load, then a stray data pulse.
    apply(mk(1, 10, 1, 1, 0, 0, 0, 0, 0, 0));
    tick();
    chk("rstw_ready_wait", 64'(bus.mw_ready), 64'd0);
    rest = 1'b1;
    apply(idle);
    tick();
    rest = 1'b0;
    check_zero("rstw");
    apply(mk(0, 0, 0, 0, 0, 32'h1234, 1, 0, 0, 0));
    tick();
    chk("rstw_stray_rf_we", 64'(bus.rf_we), 64'd0);
    chk("rstw_stray_retire", 64'(bus.wb_retire), 64'd0);
    chk("rstw_stray_ready", 64'(bus.mw_ready), 64'd1);

    // Randomized traffic against the reference model.
    do_reset();
    model_edge(idle, 1'b1);
    for (int c = 0; c < 1500; c++) begin
      r.valid = ($urandom_range(0, 9) < 6);
      r.rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      r.rw    = ($urandom_range(0, 3) != 0);
      r.sel   = $urandom_range(0, 1) == 1;
      r.rdata = $urandom;
      r.mdata = $urandom;
      r.mdv   = ($urandom_range(0, 3) == 0);
      r.cw    = $urandom_range(0, 2) == 0;
      r.csr   = 12'($urandom);
      r.cdata = $urandom;
      rst     = ($urandom_range(0, 149) == 0);
      apply(r);
      rest = rst;
      @(posedge clk);
      model_edge(r, rst);
      #1;
      rest = 1'b0;
      chk("rnd_ready", 64'(bus.mw_ready), 64'(pend.size() == 0));
      chk("rnd_rf_we", 64'(bus.rf_we), 64'(m_rf_we));
      if (m_rf_we) begin
        chk("rnd_rf_waddr", 64'(bus.rf_waddr), 64'(m_waddr));
        chk("rnd_rf_wdata", 64'(bus.rf_wdata), 64'(m_wdata));
      end
      chk("rnd_csr_we", 64'(bus.csr_we), 64'(m_csr_we));
      if (m_csr_we) begin
        chk("rnd_csr_waddr", 64'(bus.csr_waddr), 64'(m_caddr));
        chk("rnd_csr_wdata", 64'(bus.csr_wdata), 64'(m_cdata));
      end
      chk("rnd_retire", 64'(bus.wb_retire), 64'(m_retire));
      chk("rnd_instret", bus.wb_instret, m_instret);
      chk("rnd_timeout", 64'(bus.wb_load_timeout), 64'(m_tmo));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
